instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Responder side of the instruction-fetch interface: accepts one 64-bit fetch address from the program counter / fetch stage and returns the 32-bit instruction word.
- Word-addressed instruction RAM of 2^ADDR_BITS words, with a configurable fixed access latency (wait states), a valid/ready handshake on both request and response, and fault reporting.
- A side-band programming port loads the RAM from the testbench or bootloader.

Parameters:
ADDR_BITS, 10, log2 of RAM depth in 32-bit words
WAIT_STATES, 2, extra cycles between request acceptance and response (0..15)
BASE_ADDR, 64'h0, byte address mapped to RAM word 0

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous reset, active-high
REQ_VALID  in  1  fetch request valid
REQ_READY  out  1  responder can accept a request
REQ_ADDR  in  64  fetch byte address
RSP_VALID  out  1  response valid
RSP_READY  in  1  consumer accepts response
RSP_INSTR  out  32  fetched instruction
RSP_FAULT  out  1  request was misaligned or out of range
PROG_WE  in  1  program-port write enable
PROG_ADDR  in  ADDR_BITS  program-port word index
PROG_DATA  in  32  program-port write data

Behaviour:
- Reset: while RST=1 at a rising edge, state <= IDLE, wait counter <= 0, RSP_VALID <= 0, RSP_INSTR <= 32'h0, RSP_FAULT <= 0, captured address <= 0. REQ_READY is 0 while RST=1. RAM contents are not reset.
- Reset mid-operation abandons any in-flight request. No response is ever produced for it.
- FSM states:
  - IDLE: REQ_READY=1 (when RST=0), RSP_VALID=0. Request accepted on an edge with REQ_VALID=1 and REQ_READY=1. On acceptance: capture REQ_ADDR; compute fault; load counter with WAIT_STATES. Next state is WAIT if WAIT_STATES>0, otherwise RESP.
  - WAIT: REQ_READY=0. Counter decrements each cycle. On the edge where the counter is 1, go to RESP.
  - RESP: REQ_READY=0, RSP_VALID=1. RSP_INSTR and RSP_FAULT are held stable until the edge with RSP_READY=1, then go to IDLE.
- Latency: RSP_VALID rises exactly WAIT_STATES+1 cycles after the acceptance edge.
- No request is accepted in the same cycle as the response handshake. Maximum throughput is one fetch per WAIT_STATES+2 cycles.
- Data capture: RSP_INSTR and RSP_FAULT are registered on the edge entering RESP. The read uses word index (addr - BASE_ADDR) >> 2, truncated to ADDR_BITS.
- Fault: asserted when any of the following holds:
  - addr[1:0] != 0 (misaligned);
  - addr < BASE_ADDR;
  - (addr - BASE_ADDR) >> 2 >= 2^ADDR_BITS.
  - All comparisons are 64-bit unsigned.
  - On fault, RSP_INSTR = 32'h00000013 (NOP) and the RAM is not read.
  - A fault response still observes the full latency and handshake.
- Program port: on any rising edge with PROG_WE=1 and RST=0, RAM[PROG_ADDR] <= PROG_DATA. The write is independent of FSM state.
  - If the write targets the word being read on the same edge the read is captured, the old data is returned (read-before-write).
  - A write during WAIT on an earlier edge is visible in the response.
- REQ_ADDR is ignored outside the acceptance edge. RSP_READY is ignored outside RESP.

Test Plan:
- Program RAM[0..3] = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013; request addr 0x0, RSP_READY=1 -> with WAIT_STATES=2, RSP_VALID rises 3 cycles after acceptance with RSP_INSTR=32'h00500093 and RSP_FAULT=0; REQ_READY returns to 1 one cycle later.
- Back-to-back fetches at 0x4, 0x8 with REQ_VALID held high -> responses 32'h00A00113 then 32'h002081B3; accepted requests are spaced 4 cycles apart.
- Hold RSP_READY=0 for 5 cycles in RESP -> RSP_VALID stays 1 with RSP_INSTR unchanged; REQ_READY stays 0; a single handshake occurs when RSP_READY rises.
- Fault cases:
  - request 0x6 -> RSP_FAULT=1, RSP_INSTR=32'h00000013 after the normal latency;
  - request 0x1000 with ADDR_BITS=10 -> RSP_FAULT=1;
  - with BASE_ADDR=0x100, request 0xFC -> RSP_FAULT=1.
- Assert RST=1 for one cycle during WAIT after accepting 0x8 -> next cycle state is IDLE, RSP_VALID=0, RSP_INSTR=0, no response for 0x8; a new request at 0x0 completes normally.
- PROG_WE writes 32'hDEADBEEF to word 2 during WAIT of a fetch to 0x8 (before the capture edge) -> response 32'hDEADBEEF. The same write on the capture edge -> old value 32'h002081B3.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: word-addressed instruction RAM with a fixed
// access latency, valid/ready request/response handshakes, fault reporting
// for misaligned or unmapped fetches, and a side-band programming port.
module instr_mem_responder #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [63:0]          REQ_ADDR,
    output logic                 RSP_VALID,
    input  logic                 RSP_READY,
    output logic [31:0]          RSP_INSTR,
    output logic                 RSP_FAULT,
    input  logic                 PROG_WE,
    input  logic [ADDR_BITS-1:0] PROG_ADDR,
    input  logic [31:0]          PROG_DATA
);

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned DEPTH      = 2 ** ADDR_BITS;
    localparam logic [63:0] WORD_LIMIT = 64'(1) << ADDR_BITS;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam bit          ZERO_WAIT  = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [63:0]        addr_q;
    logic [31:0]        mem [DEPTH];

    logic [63:0]          cap_addr;
    logic [63:0]          cap_off;
    logic                 cap_fault;
    logic [ADDR_BITS-1:0] cap_idx;
    logic [31:0]          cap_instr;

    // Only IDLE accepts; reset forces ready low immediately.
    assign REQ_READY = (state == S_IDLE) && !RST;

    // Address used on the capture edge: live request when capturing straight
    // from IDLE (zero wait states), otherwise the address latched at acceptance.
    always_comb begin
        cap_addr  = (state == S_IDLE) ? REQ_ADDR : addr_q;
        cap_off   = cap_addr - BASE_ADDR;
        cap_fault = (cap_addr[1:0] != 2'b00)
                 || (cap_addr < BASE_ADDR)
                 || ((cap_off >> 2) >= WORD_LIMIT);
        cap_idx   = cap_off[ADDR_BITS+1:2];
        cap_instr = cap_fault ? NOP_INSTR : mem[cap_idx];
    end

    // Programming port; the FSM read sees the pre-write word on the same edge.
    always_ff @(posedge CLK) begin
        if (!RST && PROG_WE) begin
            mem[PROG_ADDR] <= PROG_DATA;
        end
    end

    // Request/response sequencing with registered response outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            RSP_VALID <= 1'b0;
            RSP_INSTR <= 32'h0;
            RSP_FAULT <= 1'b0;
            addr_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        addr_q   <= REQ_ADDR;
                        wait_cnt <= CNT_W'(WAIT_STATES);
                        if (ZERO_WAIT) begin
                            state     <= S_RESP;
                            RSP_VALID <= 1'b1;
                            RSP_INSTR <= cap_instr;
                            RSP_FAULT <= cap_fault;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (wait_cnt == CNT_W'(1)) begin
                        state     <= S_RESP;
                        RSP_VALID <= 1'b1;
                        RSP_INSTR <= cap_instr;
                        RSP_FAULT <= cap_fault;
                    end
                end
                S_RESP: begin
                    if (RSP_READY) begin
                        state     <= S_IDLE;
                        RSP_VALID <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: default-configured instance (A) plus a
// zero-wait, offset-base, 16-word instance (B), both checked against an
// array-based model of the instruction memory.
module tb_instr_mem_responder;

    localparam int          WS_A   = 2;
    localparam int          BITS_A = 10;
    localparam logic [63:0] BASE_A = 64'h0;
    localparam int          WS_B   = 0;
    localparam int          BITS_B = 4;
    localparam logic [63:0] BASE_B = 64'h100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        req_valid_a = 1'b0, req_ready_a, rsp_valid_a, rsp_ready_a = 1'b0, rsp_fault_a;
    logic [63:0] req_addr_a = '0;
    logic [31:0] rsp_instr_a, prog_data_a = '0;
    logic        prog_we_a = 1'b0;
    logic [9:0]  prog_addr_a = '0;

    logic        req_valid_b = 1'b0, req_ready_b, rsp_valid_b, rsp_ready_b = 1'b0, rsp_fault_b;
    logic [63:0] req_addr_b = '0;
    logic [31:0] rsp_instr_b, prog_data_b = '0;
    logic        prog_we_b = 1'b0;
    logic [3:0]  prog_addr_b = '0;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_a [1024];
    logic [31:0] model_b [16];

    always #5 clk = ~clk;

    instr_mem_responder #(.ADDR_BITS(BITS_A), .WAIT_STATES(WS_A), .BASE_ADDR(BASE_A)) dut_a (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid_a), .REQ_READY(req_ready_a), .REQ_ADDR(req_addr_a),
        .RSP_VALID(rsp_valid_a), .RSP_READY(rsp_ready_a), .RSP_INSTR(rsp_instr_a), .RSP_FAULT(rsp_fault_a),
        .PROG_WE(prog_we_a), .PROG_ADDR(prog_addr_a), .PROG_DATA(prog_data_a)
    );

    instr_mem_responder #(.ADDR_BITS(BITS_B), .WAIT_STATES(WS_B), .BASE_ADDR(BASE_B)) dut_b (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid_b), .REQ_READY(req_ready_b), .REQ_ADDR(req_addr_b),
        .RSP_VALID(rsp_valid_b), .RSP_READY(rsp_ready_b), .RSP_INSTR(rsp_instr_b), .RSP_FAULT(rsp_fault_b),
        .PROG_WE(prog_we_b), .PROG_ADDR(prog_addr_b), .PROG_DATA(prog_data_b)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rules: fault when misaligned, below base, or beyond the RAM.
    function automatic logic exp_fault(input logic [63:0] addr, input logic [63:0] base, input int bits);
        logic [63:0] words;
        words = 64'd1 << bits;
        if (addr % 64'd4 != 64'd0) return 1'b1;
        if (addr < base) return 1'b1;
        if ((addr - base) / 64'd4 >= words) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_index(input logic [63:0] addr, input logic [63:0] base, input int bits);
        return int'(((addr - base) / 64'd4) % (64'd1 << bits));
    endfunction

    // Data is captured on edge WS after acceptance (edge 0); earlier writes are seen.
    task automatic model_a_fetch(input logic [63:0] addr, input int wr_edge, input logic [9:0] wr_idx,
                                 input logic [31:0] wr_data, output logic [31:0] ei, output logic ef);
        if (wr_edge >= 0 && wr_edge < WS_A) model_a[wr_idx] = wr_data;
        ef = exp_fault(addr, BASE_A, BITS_A);
        ei = ef ? NOP : model_a[exp_index(addr, BASE_A, BITS_A)];
        if (wr_edge >= WS_A) model_a[wr_idx] = wr_data;
    endtask

    task automatic prog_a(input logic [9:0] idx, input logic [31:0] d);
        prog_we_a = 1'b1; prog_addr_a = idx; prog_data_a = d;
        step();
        prog_we_a = 1'b0;
        model_a[idx] = d;
    endtask

    task automatic prog_b(input logic [3:0] idx, input logic [31:0] d);
        prog_we_b = 1'b1; prog_addr_b = idx; prog_data_b = d;
        step();
        prog_we_b = 1'b0;
        model_b[idx] = d;
    endtask

    // One fetch on A; wr_edge selects the edge (0 = acceptance) carrying a program write.
    task automatic fetch_a(input logic [63:0] addr, input int hold, input int wr_edge,
                           input logic [9:0] wr_idx, input logic [31:0] wr_data,
                           output logic [31:0] instr, output logic fault, output int lat,
                           output bit stable, output logic rdy_after, output bit timeout);
        int n;
        int k;
        logic [31:0] first;
        timeout = 1'b0; stable = 1'b1; n = 0;
        while (req_ready_a !== 1'b1 && n < 50) begin step(); n++; end
        if (n >= 50) timeout = 1'b1;
        prog_addr_a = wr_idx; prog_data_a = wr_data;
        req_valid_a = 1'b1; req_addr_a = addr; k = 0;
        prog_we_a = (k == wr_edge);
        step(); k = 1;
        req_valid_a = 1'b0; req_addr_a = {$urandom, $urandom};
        while (rsp_valid_a !== 1'b1 && k < 60) begin
            prog_we_a = (k == wr_edge);
            step(); k++;
        end
        if (k >= 60) timeout = 1'b1;
        lat = k;
        first = rsp_instr_a;
        rsp_ready_a = 1'b0;
        for (int i = 0; i < hold; i++) begin
            prog_we_a = (k == wr_edge);
            step(); k++;
            if (rsp_valid_a !== 1'b1 || rsp_instr_a !== first || req_ready_a !== 1'b0) stable = 1'b0;
        end
        instr = rsp_instr_a; fault = rsp_fault_a;
        rsp_ready_a = 1'b1; prog_we_a = (k == wr_edge);
        step(); k++;
        rsp_ready_a = 1'b0; prog_we_a = 1'b0;
        if (rsp_valid_a !== 1'b0) stable = 1'b0;
        rdy_after = req_ready_a;
    endtask

    task automatic fetch_b(input logic [63:0] addr, output logic [31:0] instr, output logic fault,
                           output int lat, output bit timeout);
        int n;
        int k;
        timeout = 1'b0; n = 0;
        while (req_ready_b !== 1'b1 && n < 50) begin step(); n++; end
        if (n >= 50) timeout = 1'b1;
        req_valid_b = 1'b1; req_addr_b = addr;
        step(); k = 1;
        req_valid_b = 1'b0;
        while (rsp_valid_b !== 1'b1 && k < 60) begin step(); k++; end
        if (k >= 60) timeout = 1'b1;
        lat = k; instr = rsp_instr_b; fault = rsp_fault_b;
        rsp_ready_b = 1'b1;
        step();
        rsp_ready_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        tests++; if (req_ready_a !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %b exp 0", req_ready_a); end
        tests++; if (rsp_valid_a !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid_a); end
        tests++; if (rsp_instr_a !== 32'h0) begin fails++; $display("FAIL reset_rsp_instr got %h exp 0", rsp_instr_a); end
        tests++; if (rsp_fault_a !== 1'b0) begin fails++; $display("FAIL reset_rsp_fault got %b exp 0", rsp_fault_a); end
        tests++; if (rsp_valid_b !== 1'b0) begin fails++; $display("FAIL reset_b_rsp_valid got %b exp 0", rsp_valid_b); end
        rst = 1'b0;
        step();
        tests++; if (req_ready_a !== 1'b1) begin fails++; $display("FAIL post_reset_req_ready got %b exp 1", req_ready_a); end
        tests++; if (req_ready_b !== 1'b1) begin fails++; $display("FAIL post_reset_b_req_ready got %b exp 1", req_ready_b); end
    endtask

    task automatic init_mem();
        for (int i = 0; i < 1024; i++) prog_a(10'(i), $urandom);
        for (int i = 0; i < 16; i++) prog_b(4'(i), $urandom);
        prog_a(10'd0, 32'h00500093);
        prog_a(10'd1, 32'h00A00113);
        prog_a(10'd2, 32'h002081B3);
        prog_a(10'd3, 32'h00000013);
    endtask

    task automatic test_basic();
        logic [31:0] ins; logic flt; int lat; bit st; logic rdy; bit to;
        fetch_a(64'h0, 0, -1, 10'd0, 32'h0, ins, flt, lat, st, rdy, to);
        tests++; if (to) begin fails++; $display("FAIL basic_timeout got 1 exp 0"); end
        tests++; if (lat !== WS_A + 1) begin fails++; $display("FAIL basic_latency got %0d exp %0d", lat, WS_A + 1); end
        tests++; if (ins !== 32'h00500093) begin fails++; $display("FAIL basic_instr got %h exp 00500093", ins); end
        tests++; if (flt !== 1'b0) begin fails++; $display("FAIL basic_fault got %b exp 0", flt); end
        tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL basic_ready_after got %b exp 1", rdy); end
        tests++; if (!st) begin fails++; $display("FAIL basic_handshake got unstable exp single handshake"); end
    endtask

    task automatic test_back_to_back();
        int acc_cyc [4];
        logic [31:0] got [4];
        int na; int nr; bit acc;
        acc_cyc = '{0, 0, 0, 0};
        got = '{32'h0, 32'h0, 32'h0, 32'h0};
        na = 0; nr = 0;
        req_valid_a = 1'b1; req_addr_a = 64'h4; rsp_ready_a = 1'b1;
        for (int c = 0; c < 40 && nr < 2; c++) begin
            acc = (req_ready_a === 1'b1) && req_valid_a;
            if (rsp_valid_a === 1'b1) begin got[nr] = rsp_instr_a; nr++; end
            step();
            if (acc) begin
                acc_cyc[na] = c; na++;
                if (na == 1) req_addr_a = 64'h8; else req_valid_a = 1'b0;
            end
        end
        req_valid_a = 1'b0; rsp_ready_a = 1'b0;
        tests++; if (na !== 2) begin fails++; $display("FAIL b2b_accept_count got %0d exp 2", na); end
        tests++; if (acc_cyc[1] - acc_cyc[0] !== WS_A + 2) begin fails++; $display("FAIL b2b_spacing got %0d exp %0d", acc_cyc[1] - acc_cyc[0], WS_A + 2); end
        tests++; if (got[0] !== 32'h00A00113) begin fails++; $display("FAIL b2b_rsp0 got %h exp 00A00113", got[0]); end
        tests++; if (got[1] !== 32'h002081B3) begin fails++; $display("FAIL b2b_rsp1 got %h exp 002081B3", got[1]); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ins; logic flt; int lat; bit st; logic rdy; bit to;
        fetch_a(64'hC, 5, -1, 10'd0, 32'h0, ins, flt, lat, st, rdy, to);
        tests++; if (to) begin fails++; $display("FAIL bp_timeout got 1 exp 0"); end
        tests++; if (!st) begin fails++; $display("FAIL bp_hold got unstable exp stable"); end
        tests++; if (ins !== 32'h00000013) begin fails++; $display("FAIL bp_instr got %h exp 00000013", ins); end
        tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL bp_ready_after got %b exp 1", rdy); end
    endtask

    task automatic test_faults();
        logic [31:0] ins; logic flt; int lat; bit st; logic rdy; bit to;
        fetch_a(64'h6, 0, -1, 10'd0, 32'h0, ins, flt, lat, st, rdy, to);
        tests++; if (flt !== 1'b1 || ins !== NOP) begin fails++; $display("FAIL fault_misaligned got %b/%h exp 1/%h", flt, ins, NOP); end
        tests++; if (lat !== WS_A + 1) begin fails++; $display("FAIL fault_latency got %0d exp %0d", lat, WS_A + 1); end
        fetch_a(64'h1000, 0, -1, 10'd0, 32'h0, ins, flt, lat, st, rdy, to);
        tests++; if (flt !== 1'b1 || ins !== NOP) begin fails++; $display("FAIL fault_range got %b/%h exp 1/%h", flt, ins, NOP); end
        fetch_a(64'hFFC, 0, -1, 10'd0, 32'h0, ins, flt, lat, st, rdy, to);
        tests++; if (flt !== 1'b0 || ins !== model_a[1023]) begin fails++; $display("FAIL last_word got %b/%h exp 0/%h", flt, ins, model_a[1023]); end
        fetch_b(64'hFC, ins, flt, lat, to);
        tests++; if (flt !== 1'b1 || ins !== NOP) begin fails++; $display("FAIL fault_below_base got %b/%h exp 1/%h", flt, ins, NOP); end
        tests++; if (lat !== WS_B + 1 || to) begin fails++; $display("FAIL b_latency got %0d exp %0d", lat, WS_B + 1); end
        fetch_b(64'h100, ins, flt, lat, to);
        tests++; if (flt !== 1'b0 || ins !== model_b[0]) begin fails++; $display("FAIL b_base_word got %b/%h exp 0/%h", flt, ins, model_b[0]); end
        fetch_b(64'h13C, ins, flt, lat, to);
        tests++; if (flt !== 1'b0 || ins !== model_b[15]) begin fails++; $display("FAIL b_top_word got %b/%h exp 0/%h", flt, ins, model_b[15]); end
        fetch_b(64'h140, ins, flt, lat, to);
        tests++; if (flt !== 1'b1 || ins !== NOP) begin fails++; $display("FAIL b_above_range got %b/%h exp 1/%h", flt, ins, NOP); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ins; logic flt; int lat; bit st; logic rdy; bit to;
        int seen;
        int n;
        n = 0;
        while (req_ready_a !== 1'b1 && n < 50) begin step(); n++; end
        req_valid_a = 1'b1; req_addr_a = 64'h8;
        step();
        req_valid_a = 1'b0;
        rst = 1'b1;
        step();
        tests++; if (rsp_valid_a !== 1'b0) begin fails++; $display("FAIL midrst_rsp_valid got %b exp 0", rsp_valid_a); end
        tests++; if (rsp_instr_a !== 32'h0) begin fails++; $display("FAIL midrst_rsp_instr got %h exp 0", rsp_instr_a); end
        tests++; if (req_ready_a !== 1'b0) begin fails++; $display("FAIL midrst_req_ready got %b exp 0", req_ready_a); end
        rst = 1'b0;
        rsp_ready_a = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid_a === 1'b1) seen++;
            step();
        end
        rsp_ready_a = 1'b0;
        tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_ghost_rsp got %0d exp 0", seen); end
        fetch_a(64'h0, 0, -1, 10'd0, 32'h0, ins, flt, lat, st, rdy, to);
        tests++; if (ins !== 32'h00500093 || flt !== 1'b0 || lat !== WS_A + 1 || to)
            begin fails++; $display("FAIL midrst_refetch got %h/%b/%0d exp 00500093/0/%0d", ins, flt, lat, WS_A + 1); end
    endtask

    task automatic test_prog_port();
        logic [31:0] ins; logic flt; int lat; bit st; logic rdy; bit to;
        fetch_a(64'h8, 0, 1, 10'd2, 32'hDEADBEEF, ins, flt, lat, st, rdy, to);
        model_a[2] = 32'hDEADBEEF;
        tests++; if (ins !== 32'hDEADBEEF) begin fails++; $display("FAIL prog_wait_write got %h exp DEADBEEF", ins); end
        prog_a(10'd2, 32'h002081B3);
        fetch_a(64'h8, 0, WS_A, 10'd2, 32'hDEADBEEF, ins, flt, lat, st, rdy, to);
        model_a[2] = 32'hDEADBEEF;
        tests++; if (ins !== 32'h002081B3) begin fails++; $display("FAIL prog_capture_edge got %h exp 002081B3", ins); end
        fetch_a(64'h8, 0, -1, 10'd0, 32'h0, ins, flt, lat, st, rdy, to);
        tests++; if (ins !== 32'hDEADBEEF) begin fails++; $display("FAIL prog_after_capture got %h exp DEADBEEF", ins); end
    endtask

    task automatic test_random();
        logic [31:0] ins; logic flt; int lat; bit st; logic rdy; bit to;
        logic [31:0] ei; logic ef;
        logic [9:0] idx; logic [9:0] widx; logic [31:0] wdata;
        logic [63:0] addr;
        int kind; int hold; int wedge;
        for (int t = 0; t < 40; t++) begin
            idx = 10'($urandom);
            kind = $urandom_range(0, 4);
            case (kind)
                0, 1:    addr = {52'h0, idx, 2'b00};
                2:       addr = {52'h0, idx, 2'($urandom_range(1, 3))};
                3:       addr = {52'h0, idx, 2'b00} + 64'h1000;
                default: addr = {$urandom, $urandom} & ~64'h3;
            endcase
            hold  = $urandom_range(0, 3);
            wedge = $urandom_range(0, WS_A + 2) - 1;
            widx  = ($urandom_range(0, 1) == 1) ? idx : 10'($urandom);
            wdata = $urandom;
            model_a_fetch(addr, wedge, widx, wdata, ei, ef);
            fetch_a(addr, hold, wedge, widx, wdata, ins, flt, lat, st, rdy, to);
            tests++;
            if (to || ins !== ei || flt !== ef || lat !== WS_A + 1 || !st || rdy !== 1'b1) begin
                fails++;
                $display("FAIL rand_fetch[%0d] addr=%h wedge=%0d got %h/%b lat %0d st %0d exp %h/%b lat %0d",
                         t, addr, wedge, ins, flt, lat, st, ei, ef, WS_A + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        init_mem();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_faults();
        test_reset_mid();
        test_prog_port();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
